// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard controller: RV32 opcode
// constants, FSM encoding and the register-use decode helpers.
package hazard_unit_pkg;

  localparam logic [6:0] OPC_NONE   = 7'b0000000;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic STATE_RUN   = 1'b0;
  localparam logic STATE_STALL = 1'b1;

  typedef enum logic {
    RUN   = STATE_RUN,
    STALL = STATE_STALL
  } hz_state_e;

  // rs1 is read by everything except the U-type/JAL forms and the zero NOP.
  function automatic logic uses_rs1(input logic [6:0] opc);
    logic res;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_NONE: res = 1'b0;
      default:                               res = 1'b1;
    endcase
    return res;
  endfunction

  // rs2 is read only by R-type ALU ops, stores and branches.
  function automatic logic uses_rs2(input logic [6:0] opc);
    logic res;
    case (opc)
      OPC_OP, OPC_STORE, OPC_BRANCH: res = 1'b1;
      default:                       res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Signal bundle between the ID/EX pipeline control and the hazard unit.
interface hazard_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic [6:0]            id_opcode;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ctrl_pc_src;
  logic                  ctrl_stall;
  logic                  ctrl_id_bubble;
  logic                  ctrl_id_reg_flush;
  logic                  ctrl_zero_sel;

  // Pipeline side: presents ID/EX state, consumes the control decisions.
  modport master (
    output id_opcode, id_rs1, id_rs2, ex_is_load, ex_rd, ctrl_pc_src,
    input  ctrl_stall, ctrl_id_bubble, ctrl_id_reg_flush, ctrl_zero_sel
  );

  // Hazard unit side.
  modport slave (
    input  id_opcode, id_rs1, id_rs2, ex_is_load, ex_rd, ctrl_pc_src,
    output ctrl_stall, ctrl_id_bubble, ctrl_id_reg_flush, ctrl_zero_sel
  );
endinterface

// File: rtl/hazard_flush_ctr.sv
// Reloadable down-counter with a registered "window active" flag.
// A load pulse opens a window of exactly LOAD_VAL cycles starting on the
// next cycle; a reload during an open window restarts it.
module hazard_flush_ctr #(
  parameter int LOAD_VAL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic active
);

  localparam int             CNT_W    = $clog2(LOAD_VAL + 1);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_VAL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             active_r;

  // Next count: reload wins, otherwise count down to zero and hold.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (load) begin
      cnt_nxt_s = LOAD_CNT;
    end else if (cnt_r != CNT_ZERO) begin
      cnt_nxt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_nxt_s = CNT_ZERO;
    end
  end

  // Counter state and registered nonzero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= CNT_ZERO;
      active_r <= 1'b0;
    end else begin
      cnt_r    <= cnt_nxt_s;
      active_r <= (cnt_nxt_s != CNT_ZERO);
    end
  end

  assign active = active_r;

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller beside the ID stage: load-use stall with a
// configurable length and a wrong-path flush window sized to IMEM latency.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int IMEM_LAT        = 1,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int REG_ADDR_W      = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_unit_if.slave  hz
);

  localparam int              SC_W        = $clog2(LOAD_USE_CYCLES + 1);
  localparam logic [SC_W-1:0] SC_ZERO     = {SC_W{1'b0}};
  localparam logic [SC_W-1:0] SC_ONE      = SC_W'(1);
  localparam logic [SC_W-1:0] SC_LOAD     = SC_W'(LOAD_USE_CYCLES - 1);
  localparam logic            MULTI_STALL = (LOAD_USE_CYCLES > 1);
  localparam logic [REG_ADDR_W-1:0] REG_X0 = {REG_ADDR_W{1'b0}};

  hz_state_e       state_r;
  logic [SC_W-1:0] stall_cnt_r;
  logic            uses_rs1_s;
  logic            uses_rs2_s;
  logic            hazard_s;
  logic            flush_s;
  logic            stall_s;
  logic            bubble_s;

  assign uses_rs1_s = uses_rs1(hz.id_opcode);
  assign uses_rs2_s = uses_rs2(hz.id_opcode);

  // x0 is never a real producer, so it can never create a dependency.
  assign hazard_s = hz.ex_is_load && (hz.ex_rd != REG_X0) &&
                    ((uses_rs1_s && (hz.ex_rd == hz.id_rs1)) ||
                     (uses_rs2_s && (hz.ex_rd == hz.id_rs2)));

  hazard_flush_ctr #(
    .LOAD_VAL (IMEM_LAT)
  ) u_flush_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (hz.ctrl_pc_src),
    .active (flush_s)
  );

  // Stall/bubble select: redirect beats everything, an ongoing multi-cycle
  // stall holds, and a wrong-path ID instruction cannot raise a hazard.
  always_comb begin
    stall_s  = 1'b0;
    bubble_s = 1'b0;
    if (!rst_n) begin
      stall_s  = 1'b0;
      bubble_s = 1'b0;
    end else if (hz.ctrl_pc_src) begin
      stall_s  = 1'b0;
      bubble_s = 1'b1;
    end else if (state_r == STALL) begin
      stall_s  = 1'b1;
      bubble_s = 1'b1;
    end else if (flush_s) begin
      stall_s  = 1'b0;
      bubble_s = 1'b0;
    end else begin
      stall_s  = hazard_s;
      bubble_s = hazard_s;
    end
  end

  // Load-use FSM: RUN covers the first stall cycle, STALL the remainder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      stall_cnt_r <= SC_ZERO;
    end else begin
      case (state_r)
        RUN: begin
          if (hz.ctrl_pc_src) begin
            state_r     <= RUN;
            stall_cnt_r <= SC_ZERO;
          end else if (hazard_s && !flush_s && MULTI_STALL) begin
            state_r     <= STALL;
            stall_cnt_r <= SC_LOAD;
          end else begin
            state_r     <= RUN;
            stall_cnt_r <= stall_cnt_r;
          end
        end
        STALL: begin
          if (hz.ctrl_pc_src || (stall_cnt_r == SC_ONE)) begin
            state_r     <= RUN;
            stall_cnt_r <= SC_ZERO;
          end else begin
            state_r     <= STALL;
            stall_cnt_r <= stall_cnt_r - SC_ONE;
          end
        end
        default: begin
          state_r     <= RUN;
          stall_cnt_r <= SC_ZERO;
        end
      endcase
    end
  end

  assign hz.ctrl_stall        = stall_s;
  assign hz.ctrl_id_bubble    = bubble_s;
  assign hz.ctrl_id_reg_flush = flush_s;
  assign hz.ctrl_zero_sel     = (hz.id_opcode == OPC_NONE);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one instance with IMEM_LAT=3 and
// LOAD_USE_CYCLES=3 (a), one with defaults (b), driven with identical
// stimulus. Expected outputs are queued per step and checked mid-cycle.
module tb_hazard_unit;

  localparam logic [6:0] ADDI = 7'h13;
  localparam logic [6:0] LUI  = 7'h37;
  localparam logic [6:0] OPR  = 7'h33;
  localparam logic [6:0] NOP0 = 7'h00;

  typedef struct {
    string tag;
    logic  a_stall;
    logic  a_bubble;
    logic  a_flush;
    logic  b_stall;
    logic  b_bubble;
    logic  b_flush;
    logic  zero;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic       ctrl_pc_src;

  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  hazard_unit_if #(.REG_ADDR_W(5)) if_a ();
  hazard_unit_if #(.REG_ADDR_W(5)) if_b ();

  assign if_a.id_opcode   = id_opcode;
  assign if_a.id_rs1      = id_rs1;
  assign if_a.id_rs2      = id_rs2;
  assign if_a.ex_is_load  = ex_is_load;
  assign if_a.ex_rd       = ex_rd;
  assign if_a.ctrl_pc_src = ctrl_pc_src;
  assign if_b.id_opcode   = id_opcode;
  assign if_b.id_rs1      = id_rs1;
  assign if_b.id_rs2      = id_rs2;
  assign if_b.ex_is_load  = ex_is_load;
  assign if_b.ex_rd       = ex_rd;
  assign if_b.ctrl_pc_src = ctrl_pc_src;

  hazard_unit #(.IMEM_LAT(3), .LOAD_USE_CYCLES(3), .REG_ADDR_W(5)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_a)
  );

  hazard_unit #(.IMEM_LAT(1), .LOAD_USE_CYCLES(1), .REG_ADDR_W(5)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string fld, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, fld, obs, exp);
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard empty when output sampled");
    end else begin
      e = sb_q.pop_front();
      cmp(e.tag, "a_stall",  if_a.ctrl_stall,        e.a_stall);
      cmp(e.tag, "a_bubble", if_a.ctrl_id_bubble,    e.a_bubble);
      cmp(e.tag, "a_flush",  if_a.ctrl_id_reg_flush, e.a_flush);
      cmp(e.tag, "a_zero",   if_a.ctrl_zero_sel,     e.zero);
      cmp(e.tag, "b_stall",  if_b.ctrl_stall,        e.b_stall);
      cmp(e.tag, "b_bubble", if_b.ctrl_id_bubble,    e.b_bubble);
      cmp(e.tag, "b_flush",  if_b.ctrl_id_reg_flush, e.b_flush);
      cmp(e.tag, "b_zero",   if_b.ctrl_zero_sel,     e.zero);
    end
  endtask

  task automatic push_exp(input string tag, input logic [2:0] ea, input logic [2:0] eb);
    exp_t e;
    e.tag      = tag;
    e.a_stall  = ea[2];
    e.a_bubble = ea[1];
    e.a_flush  = ea[0];
    e.b_stall  = eb[2];
    e.b_bubble = eb[1];
    e.b_flush  = eb[0];
    e.zero     = (id_opcode == NOP0);
    sb_q.push_back(e);
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge.
  // ea/eb = {stall, bubble, flush} expected for instance a / b.
  task automatic step(input string tag, input logic [6:0] opc, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic ld, input logic [4:0] rd,
                      input logic pc, input logic [2:0] ea, input logic [2:0] eb);
    @(posedge clk);
    #1;
    id_opcode   = opc;
    id_rs1      = rs1;
    id_rs2      = rs2;
    ex_is_load  = ld;
    ex_rd       = rd;
    ctrl_pc_src = pc;
    push_exp(tag, ea, eb);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_now(input string tag, input logic [2:0] ea, input logic [2:0] eb);
    push_exp(tag, ea, eb);
    check_outputs();
  endtask

  task automatic release_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset with a live hazard pattern on the inputs.
    rst_n       = 1'b0;
    id_opcode   = ADDI;
    id_rs1      = 5'd5;
    id_rs2      = 5'd0;
    ex_is_load  = 1'b1;
    ex_rd       = 5'd5;
    ctrl_pc_src = 1'b0;
    #2;
    check_now("rst_hold", 3'b000, 3'b000);
    id_opcode = NOP0;
    #1;
    check_now("rst_zero_sel", 3'b000, 3'b000);
    release_reset();

    step("idle",       ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b000, 3'b000);
    // Load-use on rs1: a stalls 3 cycles, b stalls 1 cycle.
    step("lu_rs1",     ADDI, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 3'b110, 3'b110);
    step("lu_hold1",   ADDI, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 3'b110, 3'b000);
    step("lu_hold2",   ADDI, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 3'b110, 3'b000);
    step("lu_done",    ADDI, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 3'b000, 3'b000);
    // No false hazards.
    step("x0",         ADDI, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 3'b000, 3'b000);
    step("lui_rs1",    LUI,  5'd7, 5'd0, 1'b1, 5'd7, 1'b0, 3'b000, 3'b000);
    step("addi_rs2",   ADDI, 5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 3'b000, 3'b000);
    // rs2 hazard on an R-type op.
    step("op_rs2",     OPR,  5'd3, 5'd7, 1'b1, 5'd7, 1'b0, 3'b110, 3'b110);
    step("op_hold1",   OPR,  5'd3, 5'd7, 1'b0, 5'd0, 1'b0, 3'b110, 3'b000);
    step("op_hold2",   OPR,  5'd3, 5'd7, 1'b0, 5'd0, 1'b0, 3'b110, 3'b000);
    step("op_done",    OPR,  5'd3, 5'd7, 1'b0, 5'd0, 1'b0, 3'b000, 3'b000);
    step("nop",        NOP0, 5'd5, 5'd5, 1'b1, 5'd5, 1'b0, 3'b000, 3'b000);
    // Flush window, then a reload while it is open.
    step("pc1",        ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 3'b010, 3'b010);
    step("win1",       ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b001, 3'b001);
    step("pc2",        ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 3'b011, 3'b010);
    step("win2",       ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b001, 3'b001);
    step("win_haz",    ADDI, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 3'b001, 3'b110);
    step("win4",       ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b001, 3'b000);
    step("win_end",    ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b000, 3'b000);
    // Redirect during a multi-cycle stall.
    step("rs_haz",     ADDI, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 3'b110, 3'b110);
    step("rs_pc",      ADDI, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 3'b010, 3'b010);
    step("rs_ignore",  ADDI, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 3'b001, 3'b001);
    step("rs_win2",    ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b001, 3'b000);
    step("rs_win3",    ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b001, 3'b000);
    step("rs_end",     ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b000, 3'b000);
    // Asynchronous reset in the middle of a stall.
    step("st_haz",     ADDI, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 3'b110, 3'b110);
    step("st_hold",    ADDI, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 3'b110, 3'b000);
    #1;
    rst_n = 1'b0;
    #1;
    check_now("rst_mid_stall", 3'b000, 3'b000);
    release_reset();
    step("post_rst1",  ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b000, 3'b000);
    // Asynchronous reset with the flush counter at 2 and a hazard present.
    step("fr_pc",      ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, 3'b010, 3'b010);
    step("fr_win1",    ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b001, 3'b001);
    step("fr_win2",    ADDI, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 3'b001, 3'b110);
    #1;
    rst_n = 1'b0;
    #1;
    check_now("rst_mid_flush", 3'b000, 3'b000);
    ex_is_load = 1'b0;
    ex_rd      = 5'd0;
    release_reset();
    step("post_rst2",  ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b000, 3'b000);
    step("post_rst3",  ADDI, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 3'b000, 3'b000);
    step("post_haz",   ADDI, 5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 3'b110, 3'b110);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard leftover entries=%0d expected=0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Parametrised pipeline hazard controller for the RISC-V core. It sits beside the ID stage and extends the single-cycle redirect flush with:
- a flush window sized to a configurable synchronous-IMEM latency;
- load-use stall detection with a configurable stall length, set by DMEM latency.

Outputs drive PC/IF-ID hold, the ID-to-EX bubble mux, the IF/ID flush and the NOP zero-select.

## Interface
Parameters:
- `IMEM_LAT`, default 1: IMEM read latency in cycles, legal 1..4. Sets the flush-window length.
- `LOAD_USE_CYCLES`, default 1: stall cycles per load-use hazard, legal 1..3.
- `REG_ADDR_W`, default 5: register-index width.

Ports:
- `clk`  in  1  core clock. All state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_opcode`  in  7  opcode of the instruction in ID.
- `id_rs1`  in  REG_ADDR_W  rs1 index in ID.
- `id_rs2`  in  REG_ADDR_W  rs2 index in ID.
- `ex_is_load`  in  1  EX holds a load.
- `ex_rd`  in  REG_ADDR_W  rd index in EX.
- `ctrl_pc_src`  in  1  taken branch/jump redirect resolved in EX this cycle.
- `ctrl_stall`  out  1  hold PC and IF/ID.
- `ctrl_id_bubble`  out  1  replace the ID→EX control bundle with a NOP.
- `ctrl_id_reg_flush`  out  1  flush IF/ID (wrong-path instruction).
- `ctrl_zero_sel`  out  1  `id_opcode` == 7'b0 (NOP); combinational.

## Operation
Register-use decode (combinational, from `id_opcode`):
- `uses_rs1` = 1 for all opcodes except LUI, AUIPC, JAL and 0.
- `uses_rs2` = 1 only for OP, STORE and BRANCH.

Hazard condition:
- `hazard` = `ex_is_load` & `ex_rd`≠0 & ((`uses_rs1` & `ex_rd`==`id_rs1`) | (`uses_rs2` & `ex_rd`==`id_rs2`)).
- Index x0 never produces a hazard.

FSM states:
- RUN:
  - Outputs follow `hazard` combinationally: `ctrl_stall` = `ctrl_id_bubble` = `hazard` (gated; see Priority).
  - If `hazard` is accepted and `LOAD_USE_CYCLES` > 1: go to STALL with `stall_cnt` = `LOAD_USE_CYCLES`−1.
- STALL:
  - `ctrl_stall` = `ctrl_id_bubble` = 1. The hazard is not re-evaluated, because EX now holds a bubble.
  - `stall_cnt` decrements each cycle; return to RUN when it reaches 1.

Flush counter (`flush_cnt`, width clog2(`IMEM_LAT`+1)):
- `ctrl_pc_src` = 1 loads `flush_cnt` with `IMEM_LAT`.
- Otherwise `flush_cnt` decrements while nonzero.
- `ctrl_id_reg_flush` = registered (`flush_cnt` ≠ 0 after update). It is high for exactly `IMEM_LAT` consecutive cycles starting the cycle after `ctrl_pc_src`.
- `ctrl_pc_src` arriving during an active window reloads the counter, extending the window.

Priority:
1. `ctrl_pc_src` wins. In the same cycle: `ctrl_stall` = 0, `ctrl_id_bubble` = 1, FSM forced to RUN, `stall_cnt` cleared.
2. While `ctrl_id_reg_flush` = 1, `hazard` is ignored, because the ID instruction is wrong-path.
3. Otherwise the load-use stall applies.

## Timing
Reset (`rst_n` = 0, asynchronous, takes effect mid-cycle):
- FSM = RUN, `stall_cnt` = 0, `flush_cnt` = 0.
- `ctrl_id_reg_flush` = 0, `ctrl_stall` = 0, `ctrl_id_bubble` = 0.
- `ctrl_zero_sel` is purely combinational and tracks `id_opcode` during reset.
- Reset release is synchronous to `clk`. The first hazard can be detected in the first cycle after release.

Latency:
- Hazard → `ctrl_stall`: 0 cycles.
- `ctrl_pc_src` → `ctrl_id_reg_flush`: 1 cycle, matching the IMEM output register.
- Stall duration is exactly `LOAD_USE_CYCLES` cycles.

## Structure
- `riscv_pkg` / `Opcode.vh` supplies the opcode constants (OP, STORE, BRANCH, LUI, AUIPC, JAL).
- Add localparams for the FSM encoding RUN = 1'b0, STALL = 1'b1.
- One natural sub-module: `hazard_flush_ctr`, the parametrised reloadable down-counter with registered nonzero output. It is reusable for future MEM-stage flushes.

## Test plan
- **Load-use, rs1:** `ex_is_load`=1, `ex_rd`=5; ID = ADDI with `id_rs1`=5; `LOAD_USE_CYCLES`=1 → `ctrl_stall`=`ctrl_id_bubble`=1 for 1 cycle, then 0.
- **No false hazards:**
  - `ex_rd`=0 with `id_rs1`=0 → no stall.
  - LUI in ID with stale `id_rs1`=`ex_rd`=7 → no stall.
  - ADDI with `id_rs2`=`ex_rd`=7 (rs2 unused) → no stall.
- **Flush window:** `IMEM_LAT`=3; `ctrl_pc_src` pulse at cycle 10 → `ctrl_id_reg_flush` high on cycles 11–13 only. A second pulse at cycle 12 → high through cycle 15.
- **Redirect vs. stall:** `LOAD_USE_CYCLES`=3 with a stall begun at cycle 20; `ctrl_pc_src` at cycle 21 → `ctrl_stall`=0 at 21, FSM back in RUN at 22, `ctrl_id_reg_flush`=1 at 22. A hazard presented at 22 is ignored.
- **Reset mid-operation:** assert `rst_n`=0 asynchronously mid-STALL with `flush_cnt`=2 → all registered outputs 0 immediately. After release, no residual stall or flush.
- **NOP detect:** `id_opcode`=0 → `ctrl_zero_sel`=1; `id_opcode`=7'h13 → 0.
